// File: rtl/vmem_seq.sv
// rtl/vmem_seq.sv - vector memory sequencer: serialises five 32-bit lanes onto a
// single-word data-memory port for VLDR/VSTR.
module vmem_seq #(
  parameter int STRIDE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [31:0] base_addr,
  input  logic [31:0] st_a,
  input  logic [31:0] st_b,
  input  logic [31:0] st_c,
  input  logic [31:0] st_d,
  input  logic [31:0] st_e,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [31:0] ld_a,
  output logic [31:0] ld_b,
  output logic [31:0] ld_c,
  output logic [31:0] ld_d,
  output logic [31:0] ld_e,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic        load_q;
  logic [31:0] base_q;
  logic [31:0] st_q  [0:4];
  logic [31:0] stage [0:4];
  logic [31:0] lane_wdata;
  logic        xfer;

  assign xfer = (state == XFER);

  always_comb begin
    lane_wdata = '0;
    case (idx)
      3'd0:    lane_wdata = st_q[0];
      3'd1:    lane_wdata = st_q[1];
      3'd2:    lane_wdata = st_q[2];
      3'd3:    lane_wdata = st_q[3];
      3'd4:    lane_wdata = st_q[4];
      default: lane_wdata = '0;
    endcase
  end

  // Memory-side outputs decode straight from registers so an async reset clears them at once.
  assign mem_addr  = xfer ? (base_q + (32'(STRIDE) * {29'd0, idx})) : '0;
  assign mem_we    = xfer && !load_q;
  assign mem_wdata = (xfer && !load_q) ? lane_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      load_q <= 1'b0;
      base_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      ld_a   <= '0;
      ld_b   <= '0;
      ld_c   <= '0;
      ld_d   <= '0;
      ld_e   <= '0;
      for (int i = 0; i < 5; i++) begin
        st_q[i]  <= '0;
        stage[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (base_addr[1:0] == 2'b00) begin
              load_q  <= is_load;
              base_q  <= base_addr;
              st_q[0] <= st_a;
              st_q[1] <= st_b;
              st_q[2] <= st_c;
              st_q[3] <= st_d;
              st_q[4] <= st_e;
              idx     <= '0;
              busy    <= 1'b1;
              state   <= XFER;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (load_q) stage[idx] <= mem_rdata;
          if (idx == 3'd4) begin
            // Lane E bypasses staging so the whole vector lands in one edge.
            if (load_q) begin
              ld_a <= stage[0];
              ld_b <= stage[1];
              ld_c <= stage[2];
              ld_d <= stage[3];
              ld_e <= mem_rdata;
            end
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vmem_seq.md
# vmem_seq

Vector memory sequencer for the 5-lane vector datapath. It executes VLDR/VSTR by serialising the five 32-bit lanes onto the single-word data-memory port, one lane per cycle. Store lanes come from the same operand bundle that feeds the vector ALU. Load results are presented as a five-lane bundle at the vector writeback mux, beside VALUResultA–E. The core stalls on `busy` and writes back on `done`.

## Interface
- `STRIDE`, default 4: byte increment between consecutive lanes.
- `clk` in 1: single clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request a vector memory op. Sampled only in IDLE or DONE.
- `is_load` in 1: 1 = VLDR, 0 = VSTR. Sampled with `start`.
- `base_addr` in 32: byte address of lane A. Sampled with `start`.
- `st_a`, `st_b`, `st_c`, `st_d`, `st_e` in 32 each: store-data lanes A..E. Snapshotted with `start`.
- `mem_rdata` in 32: data-memory read data. Combinational read, same cycle as `mem_addr`.
- `mem_addr` out 32: data-memory byte address.
- `mem_we` out 1: data-memory write enable. Memory writes on the rising edge.
- `mem_wdata` out 32: data-memory write data.
- `ld_a`, `ld_b`, `ld_c`, `ld_d`, `ld_e` out 32 each: last completed load vector, held.
- `busy` out 1: transfer in progress; the core stalls.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: misaligned request. Pulses together with `done`.

## Operation
- FSM states: IDLE, XFER, DONE. Lane counter `idx` is 3 bits and runs 0..4.
- **IDLE, `start`=1, `base_addr[1:0]`=0**:
  - Latch `is_load`, `base_addr`, and `st_a..st_e`.
  - Set `idx`=0 and go to XFER.
- **IDLE, `start`=1, `base_addr[1:0]`≠0**:
  - Go to DONE with `err` set.
  - No memory access. `ld_*` unchanged.
- **XFER**:
  - `mem_addr` = latched base + `STRIDE`*`idx`, modulo 2^32; wrap-around is legal.
  - Store: `mem_we`=1, `mem_wdata` = latched lane[`idx`].
  - Load: `mem_we`=0. Capture `mem_rdata` into internal staging lane[`idx`] at the clock edge.
  - `idx`=4 → DONE. Otherwise `idx`+1.
- **DONE**:
  - `done`=1 for this single cycle.
  - On the entry edge of a successful load, copy all five staging lanes into `ld_a..ld_e` at once. `ld_*` never shows a partial vector.
  - A store, or an `err` case, leaves `ld_*` unchanged.
  - Next state:
    - `start`=1 and aligned → XFER. This is a back-to-back operation with no IDLE bubble.
    - `start`=1 and misaligned → DONE again with `err`.
    - Otherwise → IDLE.
- `start` during XFER is ignored. Inputs are not re-sampled mid-transfer, and changes on `st_*` or `base_addr` have no effect.
- Outside XFER: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. These outputs are never X.
- `busy` = (state==XFER). `err` is only ever high while `done` is high.

## Timing
- Reset values:
  - State IDLE, `idx`=0.
  - `busy`=0, `done`=0, `err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `ld_a..ld_e`=0, staging=0.
- Latency, with `start` sampled at edge E0:
  - Lane A..E accesses occupy the cycles after E0..E4.
  - `done` is high in the cycle after E5.
  - Memory writes land at edges E1..E5.
  - `ld_*` is valid from edge E5.
- Throughput: one operation per 6 cycles when `start` is held or re-asserted in DONE.
- A misaligned request gives `done` and `err` the cycle after the sampling edge: a 1-cycle op.
- Asynchronous reset at any point:
  - Immediately return to IDLE and drive `mem_we`=0.
  - Store words already written stay in memory.
  - The partial load is discarded and `ld_*` is cleared to 0.
- Deasserting reset mid-cycle produces no memory write until a new `start` is accepted.

## Test plan
- **Reset mid-store**:
  - Stimulus: assert reset while `idx`=2.
  - Required: `mem_we` drops asynchronously; only 0x200 and 0x204 were written; `busy`=0.
  - Next `start` operates normally.
- **VSTR**:
  - Stimulus: base 0x100, `st_a..e` = 0x11,0x22,0x33,0x44,0x55.
  - Required: writes at 0x100,0x104,0x108,0x10C,0x110 with matching data; `busy` high for 5 cycles, then `done`=1, `err`=0; `ld_*` unchanged.
- **VLDR**:
  - Stimulus: memory at 0x200.. holds 0xA0..0xA4.
  - Required: `ld_a..e` = 0xA0..0xA4 appear together at the `done` cycle; `mem_we` never asserted.
- **Misaligned**:
  - Stimulus: base 0x102.
  - Required: `done`=`err`=1 one cycle after `start`; no `mem_we`; `ld_*` unchanged.
- **Back-to-back**:
  - Stimulus: `start` held high across a VSTR then a VLDR to the same base.
  - Required: the second op's XFER begins directly after DONE; the load returns the just-stored values.
- **Address wrap**:
  - Stimulus: base 0xFFFFFFF8.
  - Required: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8.
